fetch_stage: RTL

Instruction-fetch stage that sits directly upstream of the combinational instruction memory and feeds the decode stage. It holds the program counter and drives PC_F into the memory. It captures the returned Instr_F together with PC_F into the IF/ID pipeline register. It also handles the hazard unit's stall and flush controls and branch/jump redirects from execute.

---
 rtl/fetch_stage.sv | 96 +++++++++
 1 files changed

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the program counter, drives the fetch address
// into a combinational instruction memory and captures the returned word into
// the IF/ID pipeline register under hazard-unit stall/flush control.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        StallF,
  input  logic        StallD,
  input  logic        FlushD,
  input  logic        PCSrc_E,
  input  logic [31:0] PCTarget_E,
  input  logic [31:0] Instr_F,
  output logic [31:0] PC_F,
  output logic [31:0] Instr_D,
  output logic [31:0] PC_D,
  output logic [31:0] PCPlus4_D,
  output logic        Valid_D,
  output logic [31:0] FetchCnt
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] id_instr_q, id_instr_d;
  logic [31:0] id_pc_q, id_pc_d;
  logic [31:0] id_pc_plus4_q, id_pc_plus4_d;
  logic        id_valid_q, id_valid_d;
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] pc_plus4;
  logic        capture;

  assign pc_plus4 = pc_q + 32'd4;
  // Only a plain capture (no flush, no stall) counts as an accepted instruction.
  assign capture  = !FlushD && !StallD;

  // PC next state: redirect beats stall; target forced word aligned.
  always_comb begin
    pc_d = pc_plus4;
    if (PCSrc_E) begin
      pc_d = {PCTarget_E[31:2], 2'b00};
    end else if (StallF) begin
      pc_d = pc_q;
    end
  end

  // IF/ID next state: flush beats stall; capture otherwise.
  always_comb begin
    id_instr_d    = Instr_F;
    id_pc_d       = pc_q;
    id_pc_plus4_d = pc_plus4;
    id_valid_d    = 1'b1;
    fetch_cnt_d   = fetch_cnt_q;
    if (FlushD) begin
      id_instr_d    = NOP_INSTR;
      id_pc_d       = 32'd0;
      id_pc_plus4_d = 32'd0;
      id_valid_d    = 1'b0;
    end else if (StallD) begin
      id_instr_d    = id_instr_q;
      id_pc_d       = id_pc_q;
      id_pc_plus4_d = id_pc_plus4_q;
      id_valid_d    = id_valid_q;
    end
    if (capture) begin
      fetch_cnt_d = fetch_cnt_q + 32'd1;
    end
  end

  // State registers with synchronous reset overriding all controls.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q          <= RESET_PC;
      id_instr_q    <= NOP_INSTR;
      id_pc_q       <= 32'd0;
      id_pc_plus4_q <= 32'd0;
      id_valid_q    <= 1'b0;
      fetch_cnt_q   <= 32'd0;
    end else begin
      pc_q          <= pc_d;
      id_instr_q    <= id_instr_d;
      id_pc_q       <= id_pc_d;
      id_pc_plus4_q <= id_pc_plus4_d;
      id_valid_q    <= id_valid_d;
      fetch_cnt_q   <= fetch_cnt_d;
    end
  end

  assign PC_F      = pc_q;
  assign Instr_D   = id_instr_q;
  assign PC_D      = id_pc_q;
  assign PCPlus4_D = id_pc_plus4_q;
  assign Valid_D   = id_valid_q;
  assign FetchCnt  = fetch_cnt_q;

endmodule
